// File: rtl/int_issue_pkg.sv
// Shared field layout and ROB-age helper for the integer issue pipeline.
// Optional bypass build macro: INT_ISSUE_BYPASS_EN.
package int_issue_pkg;

  localparam int PREG_W         = 6;
  localparam int INSTR_ID_WIDTH = 4;
  localparam int ROBID_W        = INSTR_ID_WIDTH + 1;

  localparam int PRS1_MSB  = 116;
  localparam int PRS1_LSB  = 111;
  localparam int PRS2_MSB  = 110;
  localparam int PRS2_LSB  = 105;
  localparam int ROBID_MSB = INSTR_ID_WIDTH;
  localparam int ROBID_LSB = 0;

  typedef logic [ROBID_W-1:0] robid_t;
  typedef logic [PREG_W-1:0]  preg_t;

  // MSB is the ROB wrap bit: differing wrap bits invert the plain index compare.
  function automatic logic is_younger(input robid_t a, input robid_t f);
    return (a[ROBID_W-1] != f[ROBID_W-1]) ^
           (a[ROBID_W-2:0] > f[ROBID_W-2:0]);
  endfunction

endpackage

// File: rtl/int_issue_bypass.sv
// Per-source operand select between register-file data and two writeback ports.
// With INT_ISSUE_BYPASS_EN undefined this reduces to a register-file passthrough.
module int_issue_bypass
  import int_issue_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              rd_valid,
  input  logic [PREG_W-1:0] prs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              wb0_valid,
  input  logic              wb0_need_to_wb,
  input  logic [PREG_W-1:0] wb0_prd,
  input  logic [XLEN-1:0]   wb0_data,
  input  logic              wb1_valid,
  input  logic              wb1_need_to_wb,
  input  logic [PREG_W-1:0] wb1_prd,
  input  logic [XLEN-1:0]   wb1_data,
  output logic [XLEN-1:0]   src
);

`ifdef INT_ISSUE_BYPASS_EN
  logic hit0, hit1;

  assign hit0 = rd_valid && wb0_valid && wb0_need_to_wb && (wb0_prd == prs);
  assign hit1 = rd_valid && wb1_valid && wb1_need_to_wb && (wb1_prd == prs);

  // Port 0 has priority when both ports write the same register.
  always_comb begin
    src = rf_data;
    if (hit1) src = wb1_data;
    if (hit0) src = wb0_data;
  end
`else
  logic unused_wb;

  assign src       = rf_data;
  assign unused_wb = ^{rd_valid, prs, wb0_valid, wb0_need_to_wb, wb0_prd, wb0_data,
                       wb1_valid, wb1_need_to_wb, wb1_prd, wb1_data};
`endif

endmodule

// File: rtl/int_issue_pipe.sv
// Two-stage (RD/EX) integer issue pipe between issue queue and ALU, with flush kill.
// Optional same-cycle writeback bypass when INT_ISSUE_BYPASS_EN is defined.
module int_issue_pipe
  import int_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 248,
  parameter int XLEN       = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic [DATA_WIDTH-1:0] isq2iss_data,
  input  logic                  isq2iss_valid,
  output logic                  isq2iss_ready,

  output logic [PREG_W-1:0]     rf_rs1_addr,
  output logic [PREG_W-1:0]     rf_rs2_addr,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,

  input  logic                  writeback0_valid,
  input  logic                  writeback0_need_to_wb,
  input  logic [PREG_W-1:0]     writeback0_prd,
  input  logic [XLEN-1:0]       writeback0_data,
  input  logic                  writeback1_valid,
  input  logic                  writeback1_need_to_wb,
  input  logic [PREG_W-1:0]     writeback1_prd,
  input  logic [XLEN-1:0]       writeback1_data,

  input  logic                  flush_valid,
  input  logic [ROBID_W-1:0]    flush_robid,

  output logic                  iss2alu_valid,
  input  logic                  iss2alu_ready,
  output logic [DATA_WIDTH-1:0] iss2alu_data,
  output logic [XLEN-1:0]       iss2alu_src1,
  output logic [XLEN-1:0]       iss2alu_src2
);

  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_payload;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] ex_payload;
  logic [XLEN-1:0]       ex_src1, ex_src2;

  logic                  ex_free, rd_adv, accept;
  logic                  rd_kill, ex_kill;
  logic [XLEN-1:0]       byp_src1, byp_src2;
  robid_t                rd_robid, ex_robid;

  assign rd_robid = rd_payload[ROBID_MSB:ROBID_LSB];
  assign ex_robid = ex_payload[ROBID_MSB:ROBID_LSB];

  assign rd_kill = flush_valid && rd_valid && is_younger(rd_robid, flush_robid);
  assign ex_kill = flush_valid && ex_valid && is_younger(ex_robid, flush_robid);

  assign ex_free       = !ex_valid || iss2alu_ready;
  assign rd_adv        = rd_valid && ex_free && !rd_kill;
  assign isq2iss_ready = !flush_valid && (!rd_valid || ex_free);
  assign accept        = isq2iss_valid && isq2iss_ready;

  assign rf_rs1_addr = rd_payload[PRS1_MSB:PRS1_LSB];
  assign rf_rs2_addr = rd_payload[PRS2_MSB:PRS2_LSB];

  int_issue_bypass #(.XLEN(XLEN)) u_byp_rs1 (
    .rd_valid       (rd_valid),
    .prs            (rf_rs1_addr),
    .rf_data        (rf_rs1_data),
    .wb0_valid      (writeback0_valid),
    .wb0_need_to_wb (writeback0_need_to_wb),
    .wb0_prd        (writeback0_prd),
    .wb0_data       (writeback0_data),
    .wb1_valid      (writeback1_valid),
    .wb1_need_to_wb (writeback1_need_to_wb),
    .wb1_prd        (writeback1_prd),
    .wb1_data       (writeback1_data),
    .src            (byp_src1)
  );

  int_issue_bypass #(.XLEN(XLEN)) u_byp_rs2 (
    .rd_valid       (rd_valid),
    .prs            (rf_rs2_addr),
    .rf_data        (rf_rs2_data),
    .wb0_valid      (writeback0_valid),
    .wb0_need_to_wb (writeback0_need_to_wb),
    .wb0_prd        (writeback0_prd),
    .wb0_data       (writeback0_data),
    .wb1_valid      (writeback1_valid),
    .wb1_need_to_wb (writeback1_need_to_wb),
    .wb1_prd        (writeback1_prd),
    .wb1_data       (writeback1_data),
    .src            (byp_src2)
  );

  // RD stage: accept and kill are exclusive since accept is blocked during flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      rd_payload <= '0;
    end else begin
      if (accept) begin
        rd_valid   <= 1'b1;
        rd_payload <= isq2iss_data;
      end else if (rd_kill || rd_adv) begin
        rd_valid   <= 1'b0;
      end
    end
  end

  // EX stage: a killed entry is simply dropped; it never handshakes with the ALU.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid   <= 1'b0;
      ex_payload <= '0;
      ex_src1    <= '0;
      ex_src2    <= '0;
    end else begin
      if (rd_adv) begin
        ex_valid   <= 1'b1;
        ex_payload <= rd_payload;
        ex_src1    <= byp_src1;
        ex_src2    <= byp_src2;
      end else if (ex_kill || iss2alu_ready) begin
        ex_valid   <= 1'b0;
      end
    end
  end

  assign iss2alu_valid = ex_valid && !ex_kill;
  assign iss2alu_data  = ex_payload;
  assign iss2alu_src1  = ex_src1;
  assign iss2alu_src2  = ex_src2;

endmodule

// File: tb/tb_int_issue_pipe.sv
// Directed bench for int_issue_pipe: latency, throughput, backpressure, flush, bypass, reset.
module tb_int_issue_pipe;

  localparam int DW = 248;
  localparam int XL = 64;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] isq2iss_data;
  logic          isq2iss_valid;
  logic          isq2iss_ready;
  logic [5:0]    rf_rs1_addr, rf_rs2_addr;
  logic [XL-1:0] rf_rs1_data, rf_rs2_data;
  logic          writeback0_valid, writeback0_need_to_wb;
  logic [5:0]    writeback0_prd;
  logic [XL-1:0] writeback0_data;
  logic          writeback1_valid, writeback1_need_to_wb;
  logic [5:0]    writeback1_prd;
  logic [XL-1:0] writeback1_data;
  logic          flush_valid;
  logic [4:0]    flush_robid;
  logic          iss2alu_valid;
  logic          iss2alu_ready;
  logic [DW-1:0] iss2alu_data;
  logic [XL-1:0] iss2alu_src1, iss2alu_src2;

  logic [XL-1:0] rf [64];
  int            total  = 0;
  int            passed = 0;

  always #5 clock = ~clock;

  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  int_issue_pipe #(.DATA_WIDTH(DW), .XLEN(XL)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .isq2iss_data          (isq2iss_data),
    .isq2iss_valid         (isq2iss_valid),
    .isq2iss_ready         (isq2iss_ready),
    .rf_rs1_addr           (rf_rs1_addr),
    .rf_rs2_addr           (rf_rs2_addr),
    .rf_rs1_data           (rf_rs1_data),
    .rf_rs2_data           (rf_rs2_data),
    .writeback0_valid      (writeback0_valid),
    .writeback0_need_to_wb (writeback0_need_to_wb),
    .writeback0_prd        (writeback0_prd),
    .writeback0_data       (writeback0_data),
    .writeback1_valid      (writeback1_valid),
    .writeback1_need_to_wb (writeback1_need_to_wb),
    .writeback1_prd        (writeback1_prd),
    .writeback1_data       (writeback1_data),
    .flush_valid           (flush_valid),
    .flush_robid           (flush_robid),
    .iss2alu_valid         (iss2alu_valid),
    .iss2alu_ready         (iss2alu_ready),
    .iss2alu_data          (iss2alu_data),
    .iss2alu_src1          (iss2alu_src1),
    .iss2alu_src2          (iss2alu_src2)
  );

  function automatic logic [DW-1:0] mk(input int tag, input int prs1, input int prs2, input int robid);
    logic [DW-1:0] d;
    d = '0;
    d[247:240] = 8'(tag);
    d[116:111] = 6'(prs1);
    d[110:105] = 6'(prs2);
    d[4:0]     = 5'(robid);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_wb(input int port, input logic v, input logic need, input int prd, input logic [XL-1:0] data);
    if (port == 0) begin
      writeback0_valid = v; writeback0_need_to_wb = need;
      writeback0_prd = 6'(prd); writeback0_data = data;
    end else begin
      writeback1_valid = v; writeback1_need_to_wb = need;
      writeback1_prd = 6'(prd); writeback1_data = data;
    end
  endtask

  logic [DW-1:0] b [4];
  logic [DW-1:0] c [4];
  logic [DW-1:0] p, q;

  initial begin
    for (int a = 0; a < 64; a++) rf[a] = 64'hF000_0000_0000_0000 + 64'(a) * 64'h0101;
    rf[5] = 64'h11;
    rf[7] = 64'h22;
    reset_n = 1'b0;
    isq2iss_data = '0; isq2iss_valid = 1'b0;
    set_wb(0, 1'b0, 1'b0, 0, '0);
    set_wb(1, 1'b0, 1'b0, 0, '0);
    flush_valid = 1'b0; flush_robid = '0;
    iss2alu_ready = 1'b1;

    repeat (2) @(negedge clock);
    chk("rst_alu_valid", 256'(iss2alu_valid), 256'(0));
    chk("rst_isq_ready", 256'(isq2iss_ready), 256'(1));
    chk("rst_src1", 256'(iss2alu_src1), 256'(0));
    chk("rst_src2", 256'(iss2alu_src2), 256'(0));
    chk("rst_data", 256'(iss2alu_data), 256'(0));
    chk("rst_rf_addr", 256'(rf_rs1_addr), 256'(0));
    reset_n = 1'b1;

    // Single issue, 2-cycle latency
    @(negedge clock);
    p = mk(1, 5, 7, 1);
    isq2iss_valid = 1'b1; isq2iss_data = p;
    @(negedge clock);
    isq2iss_valid = 1'b0;
    chk("lat_rf_addr1", 256'(rf_rs1_addr), 256'(5));
    chk("lat_rf_addr2", 256'(rf_rs2_addr), 256'(7));
    chk("lat_early", 256'(iss2alu_valid), 256'(0));
    @(negedge clock);
    chk("lat_valid", 256'(iss2alu_valid), 256'(1));
    chk("lat_src1", 256'(iss2alu_src1), 256'(64'h11));
    chk("lat_src2", 256'(iss2alu_src2), 256'(64'h22));
    chk("lat_data", 256'(iss2alu_data), 256'(p));
    @(negedge clock);
    chk("lat_drain", 256'(iss2alu_valid), 256'(0));

    // Back-to-back throughput
    for (int i = 0; i < 4; i++) b[i] = mk(16 + i, 10 + i, 20 + i, i);
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      if (k >= 2 && k <= 5) begin
        chk("b2b_valid", 256'(iss2alu_valid), 256'(1));
        chk("b2b_data", 256'(iss2alu_data), 256'(b[k-2]));
        chk("b2b_src1", 256'(iss2alu_src1), 256'(rf[10 + k - 2]));
        chk("b2b_src2", 256'(iss2alu_src2), 256'(rf[20 + k - 2]));
      end
      if (k == 6) chk("b2b_drain", 256'(iss2alu_valid), 256'(0));
      if (k < 4) begin
        isq2iss_valid = 1'b1; isq2iss_data = b[k];
      end else isq2iss_valid = 1'b0;
    end

    // Backpressure
    for (int i = 0; i < 4; i++) c[i] = mk(32 + i, 30 + i, 40 + i, 8 + i);
    @(negedge clock);
    iss2alu_ready = 1'b0; isq2iss_valid = 1'b1; isq2iss_data = c[0];
    @(negedge clock);
    isq2iss_data = c[1];
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      chk("bp_isq_ready_low", 256'(isq2iss_ready), 256'(0));
      chk("bp_hold_valid", 256'(iss2alu_valid), 256'(1));
      chk("bp_hold_data", 256'(iss2alu_data), 256'(c[0]));
      chk("bp_hold_src1", 256'(iss2alu_src1), 256'(rf[30]));
      isq2iss_data = c[2];
    end
    iss2alu_ready = 1'b1;
    #1 chk("bp_release_ready", 256'(isq2iss_ready), 256'(1));
    @(negedge clock);
    chk("bp_out1", 256'(iss2alu_data), 256'(c[1]));
    chk("bp_out1_src2", 256'(iss2alu_src2), 256'(rf[41]));
    isq2iss_data = c[3];
    @(negedge clock);
    chk("bp_out2", 256'(iss2alu_data), 256'(c[2]));
    isq2iss_valid = 1'b0;
    @(negedge clock);
    chk("bp_out3", 256'(iss2alu_data), 256'(c[3]));
    chk("bp_out3_valid", 256'(iss2alu_valid), 256'(1));
    @(negedge clock);
    chk("bp_drain", 256'(iss2alu_valid), 256'(0));

    // Flush: RD robid 4 killed, EX robid 2 issued, accept blocked
    p = mk(48, 1, 2, 2);
    q = mk(49, 3, 4, 4);
    @(negedge clock);
    iss2alu_ready = 1'b0; isq2iss_valid = 1'b1; isq2iss_data = p;
    @(negedge clock);
    isq2iss_data = q;
    @(negedge clock);
    isq2iss_data = mk(50, 6, 6, 1);
    flush_valid = 1'b1; flush_robid = 5'h03; iss2alu_ready = 1'b1;
    #1;
    chk("fl_isq_ready", 256'(isq2iss_ready), 256'(0));
    chk("fl_ex_issue", 256'(iss2alu_valid), 256'(1));
    chk("fl_ex_data", 256'(iss2alu_data), 256'(p));
    @(negedge clock);
    flush_valid = 1'b0; isq2iss_valid = 1'b0;
    chk("fl_rd_killed", 256'(iss2alu_valid), 256'(0));
    @(negedge clock);
    chk("fl_no_accept", 256'(iss2alu_valid), 256'(0));

    // Flush kills a younger EX entry while ALU stalled
    @(negedge clock);
    iss2alu_ready = 1'b0; isq2iss_valid = 1'b1; isq2iss_data = mk(51, 1, 1, 6);
    @(negedge clock);
    isq2iss_valid = 1'b0;
    @(negedge clock);
    chk("exk_pre_valid", 256'(iss2alu_valid), 256'(1));
    flush_valid = 1'b1; flush_robid = 5'h05;
    #1 chk("exk_valid_masked", 256'(iss2alu_valid), 256'(0));
    @(negedge clock);
    flush_valid = 1'b0; iss2alu_ready = 1'b1;
    #1 chk("exk_cleared", 256'(iss2alu_valid), 256'(0));

    // Wrap-bit flush: flush 0x0F kills RD robid 0x11
    @(negedge clock);
    isq2iss_valid = 1'b1; isq2iss_data = mk(52, 2, 3, 5'h11);
    @(negedge clock);
    isq2iss_valid = 1'b0; flush_valid = 1'b1; flush_robid = 5'h0F;
    @(negedge clock);
    flush_valid = 1'b0;
    chk("wrap_killed", 256'(iss2alu_valid), 256'(0));
    @(negedge clock);
    chk("wrap_killed2", 256'(iss2alu_valid), 256'(0));

    // Writeback bypass (rf holds stale values)
    @(negedge clock);
    isq2iss_valid = 1'b1; isq2iss_data = mk(53, 5, 9, 1);
    @(negedge clock);
    isq2iss_valid = 1'b0;
    set_wb(0, 1'b1, 1'b1, 5, 64'hAA);
    set_wb(1, 1'b1, 1'b1, 5, 64'hBB);
    @(negedge clock);
    set_wb(0, 1'b0, 1'b0, 0, '0);
    set_wb(1, 1'b0, 1'b0, 0, '0);
    chk("byp_valid", 256'(iss2alu_valid), 256'(1));
`ifdef INT_ISSUE_BYPASS_EN
    chk("byp_src1_port0", 256'(iss2alu_src1), 256'(64'hAA));
`else
    chk("byp_src1_rf", 256'(iss2alu_src1), 256'(64'h11));
`endif
    chk("byp_src2_rf", 256'(iss2alu_src2), 256'(rf[9]));
    isq2iss_valid = 1'b1; isq2iss_data = mk(54, 9, 5, 2);
    @(negedge clock);
    isq2iss_valid = 1'b0;
    set_wb(0, 1'b1, 1'b0, 9, 64'hDD);
    set_wb(1, 1'b1, 1'b1, 9, 64'hEE);
    @(negedge clock);
    set_wb(0, 1'b0, 1'b0, 0, '0);
    set_wb(1, 1'b0, 1'b0, 0, '0);
`ifdef INT_ISSUE_BYPASS_EN
    chk("byp_src1_port1", 256'(iss2alu_src1), 256'(64'hEE));
`else
    chk("byp_src1_rf9", 256'(iss2alu_src1), 256'(rf[9]));
`endif
    chk("byp2_src2_rf", 256'(iss2alu_src2), 256'(64'h11));

    // Asynchronous reset mid-flight
    @(negedge clock);
    isq2iss_valid = 1'b1; isq2iss_data = mk(55, 4, 4, 3);
    @(negedge clock);
    isq2iss_valid = 1'b0;
    @(negedge clock);
    chk("arst_pre_valid", 256'(iss2alu_valid), 256'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 256'(iss2alu_valid), 256'(0));
    chk("arst_data", 256'(iss2alu_data), 256'(0));
    chk("arst_rf_addr", 256'(rf_rs1_addr), 256'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("arst_after", 256'(iss2alu_valid), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/int_issue_pipe.md
# int_issue_pipe

Two-stage integer issue pipeline that sits directly downstream of the integer issue queue. It accepts one ready instruction per cycle from the queue's dequeue port, reads both source operands from the physical register file, optionally bypasses same-cycle writeback results, and presents the instruction with operands to the integer ALU under a valid/ready handshake. Entries younger than a redirecting instruction are killed on flush.

## Interface
- DATA_WIDTH, 248, issue-queue payload width
- XLEN, 64, operand width
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- isq2iss_data  in  DATA_WIDTH  payload from issue-queue dequeue
- isq2iss_valid  in  1  payload valid
- isq2iss_ready  out  1  this block accepts payload this cycle
- rf_rs1_addr, rf_rs2_addr  out  `PREG_RANGE  register-file read addresses, taken from the RD-stage payload
- rf_rs1_data, rf_rs2_data  in  XLEN  combinational read data
- writeback0_valid / writeback0_need_to_wb  in  1 each  writeback port 0 qualifiers
- writeback0_prd  in  `PREG_RANGE; writeback0_data  in  XLEN
- writeback1_valid / _need_to_wb / _prd / _data  same as port 0
- flush_valid  in  1; flush_robid  in  `INSTR_ID_WIDTH+1  redirecting instruction id, MSB is wrap bit
- iss2alu_valid  out  1; iss2alu_ready  in  1
- iss2alu_data  out  DATA_WIDTH; iss2alu_src1, iss2alu_src2  out  XLEN

## Operation
- Payload fields (package constants): prs1 [116:111], prs2 [110:105], robid [`INSTR_ID_WIDTH:0].
- RD stage: rd_valid, rd_payload. EX stage: ex_valid, ex_payload, ex_src1, ex_src2.
- ex_free = !ex_valid || iss2alu_ready; rd_adv = rd_valid && ex_free && !rd_kill.
- isq2iss_ready = !flush_valid && (!rd_valid || ex_free). Accept = isq2iss_valid && isq2iss_ready → rd_payload loaded, rd_valid set.
- rf_rs*_addr driven from rd_payload every cycle (valid or not).
- On rd_adv: EX loads rd_payload and operands. Operand select per source: bypass hit (see Configuration) else rf data; if both writeback ports hit, port 0 wins.
- RD empties when it advances and no new accept; EX empties when iss2alu_ready and no rd_adv.
- Younger test: younger(a,f) = (a.msb != f.msb) XOR (a[lo] > f[lo]); equal id is not younger.
- Flush: rd_kill = flush_valid && rd_valid && younger(rd.robid, flush_robid); ex_kill likewise. Killed stages clear valid at the edge; killed EX does not handshake: iss2alu_valid = ex_valid && !ex_kill.
- No accept during flush cycle. Non-younger entries proceed normally during flush.
- Reset: rd_valid, ex_valid = 0; all payload/operand registers = 0; hence iss2alu_valid = 0, iss2alu_data/src = 0, isq2iss_ready = 1 after reset release, rf addresses = 0.

## Timing
- Accept at edge N → RD valid N+1 → iss2alu_valid N+2 (2-cycle latency) when ALU ready.
- Throughput 1 instr/cycle with iss2alu_ready held high.
- Backpressure: ALU stall holds EX; RD holds one more; isq2iss_ready drops the cycle both are full and ALU not ready.
- iss2alu_data/src stable while iss2alu_valid && !iss2alu_ready.
- Register file written at end of writeback cycle; a writeback in cycle C is visible on rf_rs*_data in C+1.
- Reset assertion mid-operation discards all in-flight entries immediately (asynchronous).

## Configuration
- INT_ISSUE_BYPASS_EN defined: while rd_valid, source hits if writebackK_valid && writebackK_need_to_wb && writebackK_prd == prsN; EX captures writebackK_data.
- Undefined: operands always from rf_rs*_data; writeback ports unused (tie-off tolerated); issue queue must only issue after the cycle following writeback.

## Structure
- Shared package int_issue_pkg: field LSB/MSB constants for prs1, prs2, robid; robid_t typedef; function is_younger().
- One sub-module natural: int_issue_bypass (per-source 2-port compare/mux, instantiated twice, compiled to passthrough without the macro).
- Two stage registers inline in top.

## Test plan
- Reset → iss2alu_valid=0, isq2iss_ready=1, iss2alu_src1/src2=0.
- Issue prs1=5, prs2=7, rf[5]=0x11, rf[7]=0x22, ALU ready → iss2alu_valid 2 cycles later, src1=0x11, src2=0x22; back-to-back 4 instrs → 4 consecutive valid cycles.
- iss2alu_ready=0 for 3 cycles with continuous issue → isq2iss_ready low after RD+EX full; EX output stable; release → no loss, order kept.
- Bypass (macro on): writeback0 prd=5 data=0xAA and writeback1 prd=5 data=0xBB while RD holds prs1=5, rf stale → src1=0xAA.
- Flush robid=0x03 with RD robid=0x04, EX robid=0x02 → RD killed, EX issued; wrap case flush=0x0F (msb 0), RD robid=0x11 (msb 1, lo 1) → killed.
- Flush cycle with isq2iss_valid=1 → isq2iss_ready=0, payload not accepted.
